// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state type and key classification helper
// for the keypad entry controller.
package keypad_pkg;

    localparam logic [4:0] KEY_BKSP  = 5'd16;
    localparam logic [4:0] KEY_CLR   = 5'd17;
    localparam logic [4:0] KEY_ENTER = 5'd18;
    localparam logic [4:0] KEY_RSVD  = 5'd19;

    typedef enum logic {
        ENTRY,
        SEND
    } state_t;

    function automatic logic is_digit(input logic [4:0] key);
        return key < 5'd16;
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Operand hand-off channel: valid/ready handshake carrying one WIDTH-bit operand.
interface keypad_entry_ctrl_if #(
    parameter int WIDTH = 32
) ();

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);

endinterface

// File: rtl/keypad_entry_ctrl_key_event_gate.sv
// Turns the level keyclk strobe into a single-cycle accept pulse, with a
// post-accept lockout window that drops (not defers) further rising edges.
module key_event_gate #(
    parameter int LOCKOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic keyclk,
    input  logic enable,
    output logic key_accept
);

    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT);

    logic       keyclk_q;
    logic [7:0] lock_cnt;

    assign key_accept = keyclk & ~keyclk_q & (lock_cnt == '0) & enable;

    // keyclk_q follows keyclk even while disabled, so a key held across
    // the return to ENTRY does not produce a late event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            keyclk_q <= 1'b0;
            lock_cnt <= '0;
        end else begin
            keyclk_q <= keyclk;
            if (key_accept)
                lock_cnt <= LOCK_LOAD;
            else if (lock_cnt != '0)
                lock_cnt <= lock_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Accumulates keypad hex digits into an operand (with backspace/clear/enter)
// and offers each entered operand on a valid/ready channel.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int LOCKOUT = 255,
    localparam int CW      = $clog2(WIDTH/4 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           keycode,
    input  logic                 keyclk,
    keypad_entry_ctrl_if.master  downstream,
    output logic [WIDTH-1:0]     disp_data,
    output logic [CW-1:0]        digit_cnt,
    output logic                 overflow
);

    localparam logic [CW-1:0] MAX_DIGITS = CW'(WIDTH/4);
    localparam logic [CW-1:0] ONE        = CW'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] data_q, data_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             ovf, ovf_nx;
    logic             key_accept;

    key_event_gate #(
        .LOCKOUT (LOCKOUT)
    ) u_gate (
        .clk        (clk),
        .rst        (rst),
        .keyclk     (keyclk),
        .enable     (state == ENTRY),
        .key_accept (key_accept)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ENTRY;
            acc    <= '0;
            data_q <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            data_q <= data_nx;
            cnt    <= cnt_nx;
            ovf    <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        data_nx  = data_q;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        case (state)
            ENTRY: begin
                if (key_accept) begin
                    if (is_digit(keycode)) begin
                        // Truncation drops the top nibble once the accumulator is full.
                        acc_nx = WIDTH'({acc, keycode[3:0]});
                        if (cnt < MAX_DIGITS)
                            cnt_nx = cnt + ONE;
                        else
                            ovf_nx = 1'b1;
                    end else begin
                        case (keycode)
                            KEY_BKSP: begin
                                acc_nx = acc >> 4;
                                if (cnt != '0)
                                    cnt_nx = cnt - ONE;
                            end
                            KEY_CLR: begin
                                acc_nx = '0;
                                cnt_nx = '0;
                                ovf_nx = 1'b0;
                            end
                            KEY_ENTER: begin
                                if (cnt != '0) begin
                                    data_nx  = acc;
                                    acc_nx   = '0;
                                    cnt_nx   = '0;
                                    ovf_nx   = 1'b0;
                                    state_nx = SEND;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            SEND: begin
                if (downstream.out_ready)
                    state_nx = ENTRY;
            end
            default: state_nx = ENTRY;
        endcase
    end

    assign downstream.out_valid = (state == SEND);
    assign downstream.out_data  = data_q;
    assign disp_data            = acc;
    assign digit_cnt            = cnt;
    assign overflow             = ovf;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed sequences on a 32-bit/255-lockout instance,
// a vector table, lockout edges and a randomized model comparison on an 8-bit/20-lockout instance.
module tb_keypad_entry_ctrl;
    import keypad_pkg::*;

    localparam int WA = 32;
    localparam int LA = 255;
    localparam int WB = 8;
    localparam int LB = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]    kc_a, kc_b;
    logic          kk_a, kk_b;
    logic [WA-1:0] disp_a;
    logic [3:0]    cnt_a;
    logic          ovf_a;
    logic [WB-1:0] disp_b;
    logic [1:0]    cnt_b;
    logic          ovf_b;

    keypad_entry_ctrl_if #(.WIDTH(WA)) bus_a ();
    keypad_entry_ctrl_if #(.WIDTH(WB)) bus_b ();

    keypad_entry_ctrl #(.WIDTH(WA), .LOCKOUT(LA)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .keycode    (kc_a),
        .keyclk     (kk_a),
        .downstream (bus_a.master),
        .disp_data  (disp_a),
        .digit_cnt  (cnt_a),
        .overflow   (ovf_a)
    );

    keypad_entry_ctrl #(.WIDTH(WB), .LOCKOUT(LB)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .keycode    (kc_b),
        .keyclk     (kk_b),
        .downstream (bus_b.master),
        .disp_data  (disp_b),
        .digit_cnt  (cnt_b),
        .overflow   (ovf_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_a(input logic [4:0] code, input int gap);
        kc_a = code;
        kk_a = 1'b1;
        cycles(4);
        kk_a = 1'b0;
        cycles(gap);
    endtask

    task automatic press_b(input logic [4:0] code, input int gap);
        kc_b = code;
        kk_b = 1'b1;
        cycles(4);
        kk_b = 1'b0;
        cycles(gap);
    endtask

    // Two rises of the same key, the second 'sep' cycles after the first.
    task automatic double_rise_b(input logic [4:0] code, input int sep);
        kc_b = code;
        kk_b = 1'b1;
        cycles(4);
        kk_b = 1'b0;
        cycles(sep - 4);
        kk_b = 1'b1;
        cycles(2);
        kk_b = 1'b0;
        cycles(25);
    endtask

    typedef struct {
        logic [4:0] key;
        logic [7:0] disp;
        logic [1:0] cnt;
        logic       ovf;
        logic       valid;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[18];

    // Reference model for instance B: digits held as a list, newest last.
    int unsigned m_digs[$];
    logic        m_ovf;
    logic        m_send;
    logic [7:0]  m_data;
    logic        m_prev;
    int          m_last;
    int          m_cyc;

    function automatic logic [7:0] m_value();
        int unsigned v = 0;
        foreach (m_digs[i]) v = v * 16 + m_digs[i];
        return 8'(v);
    endfunction

    task automatic m_key(input logic [4:0] k);
        if (k < 5'd16) begin
            m_digs.push_back(int'(k));
            if (m_digs.size() > WB/4) begin
                void'(m_digs.pop_front());
                m_ovf = 1'b1;
            end
        end else if (k == KEY_BKSP) begin
            if (m_digs.size() > 0) void'(m_digs.pop_back());
        end else if (k == KEY_CLR) begin
            m_digs.delete();
            m_ovf = 1'b0;
        end else if (k == KEY_ENTER) begin
            if (m_digs.size() > 0) begin
                m_data = m_value();
                m_send = 1'b1;
                m_digs.delete();
                m_ovf = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{5'd10,     8'h0A, 2'd1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{5'd11,     8'hAB, 2'd2, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{5'd12,     8'hBC, 2'd2, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{KEY_CLR,   8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{5'd7,      8'h07, 2'd1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{5'd8,      8'h78, 2'd2, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{KEY_BKSP,  8'h07, 2'd1, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{KEY_BKSP,  8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{KEY_BKSP,  8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{KEY_BKSP,  8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{KEY_RSVD,  8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{KEY_ENTER, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{5'd15,     8'h0F, 2'd1, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{5'd0,      8'hF0, 2'd2, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{5'd1,      8'h01, 2'd2, 1'b1, 1'b0, 8'h00};
        vecs[15] = '{KEY_BKSP,  8'h00, 2'd1, 1'b1, 1'b0, 8'h00};
        vecs[16] = '{5'd2,      8'h02, 2'd2, 1'b1, 1'b0, 8'h00};
        vecs[17] = '{KEY_ENTER, 8'h00, 2'd0, 1'b0, 1'b1, 8'h02};

        kc_a = '0; kk_a = 1'b0; bus_a.out_ready = 1'b0;
        kc_b = '0; kk_b = 1'b0; bus_b.out_ready = 1'b0;
        rst = 1'b0;
        cycles(3);
        rst = 1'b1;

        chk("rst_valid_a", 64'(bus_a.out_valid), 64'(0));
        chk("rst_data_a",  64'(bus_a.out_data),  64'(0));
        chk("rst_disp_a",  64'(disp_a),          64'(0));
        chk("rst_cnt_a",   64'(cnt_a),           64'(0));
        chk("rst_ovf_a",   64'(ovf_a),           64'(0));
        chk("rst_valid_b", 64'(bus_b.out_valid), 64'(0));
        chk("rst_disp_b",  64'(disp_b),          64'(0));
        chk("rst_cnt_b",   64'(cnt_b),           64'(0));
        cycles(1);

        // Instance A: 1,2,3 then ENTER with the consumer always ready.
        bus_a.out_ready = 1'b1;
        press_a(5'd1, 260);
        press_a(5'd2, 260);
        press_a(5'd3, 260);
        chk("a_disp_123", 64'(disp_a), 64'h123);
        chk("a_cnt_3",    64'(cnt_a),  64'(3));
        kc_a = KEY_ENTER;
        kk_a = 1'b1;
        cycles(1);
        chk("a_enter_valid", 64'(bus_a.out_valid), 64'(1));
        chk("a_enter_data",  64'(bus_a.out_data),  64'h123);
        chk("a_enter_cnt",   64'(cnt_a),           64'(0));
        chk("a_enter_disp",  64'(disp_a),          64'(0));
        cycles(1);
        chk("a_valid_one_cycle", 64'(bus_a.out_valid), 64'(0));
        kk_a = 1'b0;
        cycles(260);

        // Instance A: consumer stalls; key strobes during SEND are discarded.
        bus_a.out_ready = 1'b0;
        press_a(5'd10, 260);
        press_a(5'd11, 260);
        chk("a_disp_ab", 64'(disp_a), 64'hAB);
        kc_a = KEY_ENTER;
        kk_a = 1'b1;
        cycles(4);
        kk_a = 1'b0;
        for (int i = 0; i < 300; i++) begin
            chk("a_stall_valid", 64'(bus_a.out_valid), 64'(1));
            chk("a_stall_data",  64'(bus_a.out_data),  64'hAB);
            if (i == 280) begin
                kc_a = 5'd5;
                kk_a = 1'b1;
            end
            if (i == 284) kk_a = 1'b0;
            cycles(1);
        end
        chk("a_stall_disp", 64'(disp_a), 64'(0));
        chk("a_stall_cnt",  64'(cnt_a),  64'(0));
        // Handshake and a key rise in the same cycle: key is ignored.
        kc_a = 5'd6;
        kk_a = 1'b1;
        bus_a.out_ready = 1'b1;
        cycles(1);
        chk("a_hs_valid_drop", 64'(bus_a.out_valid), 64'(0));
        cycles(5);
        chk("a_hs_key_ignored_disp", 64'(disp_a),  64'(0));
        chk("a_hs_key_ignored_cnt",  64'(cnt_a),   64'(0));
        chk("a_hs_data_kept",        64'(bus_a.out_data), 64'hAB);
        kk_a = 1'b0;
        cycles(260);

        // Instance A: reset while in SEND.
        press_a(5'd5, 260);
        press_a(5'd5, 260);
        bus_a.out_ready = 1'b0;
        kc_a = KEY_ENTER;
        kk_a = 1'b1;
        cycles(2);
        kk_a = 1'b0;
        chk("a_send_valid", 64'(bus_a.out_valid), 64'(1));
        chk("a_send_data",  64'(bus_a.out_data),  64'h55);
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        chk("a_midrst_valid", 64'(bus_a.out_valid), 64'(0));
        chk("a_midrst_data",  64'(bus_a.out_data),  64'(0));
        chk("a_midrst_disp",  64'(disp_a),          64'(0));
        chk("a_midrst_cnt",   64'(cnt_a),           64'(0));
        // Lockout is cleared by reset, so a key straight away is taken.
        press_a(5'd9, 5);
        chk("a_postrst_key", 64'(disp_a), 64'h9);

        // Instance B: vector table, consumer held off.
        bus_b.out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            press_b(vecs[i].key, 22);
            chk($sformatf("tab%0d_disp", i),  64'(disp_b),          64'(vecs[i].disp));
            chk($sformatf("tab%0d_cnt", i),   64'(cnt_b),           64'(vecs[i].cnt));
            chk($sformatf("tab%0d_ovf", i),   64'(ovf_b),           64'(vecs[i].ovf));
            chk($sformatf("tab%0d_valid", i), 64'(bus_b.out_valid), 64'(vecs[i].valid));
            chk($sformatf("tab%0d_data", i),  64'(bus_b.out_data),  64'(vecs[i].data));
        end
        bus_b.out_ready = 1'b1;
        cycles(1);
        chk("b_tab_release", 64'(bus_b.out_valid), 64'(0));

        // Instance B: lockout boundaries (LOCKOUT=20).
        press_b(KEY_CLR, 22);
        double_rise_b(5'd4, 10);
        chk("b_lock10_disp", 64'(disp_b), 64'h04);
        chk("b_lock10_cnt",  64'(cnt_b),  64'(1));
        press_b(KEY_CLR, 22);
        double_rise_b(5'd4, 20);
        chk("b_lock20_disp", 64'(disp_b), 64'h04);
        chk("b_lock20_cnt",  64'(cnt_b),  64'(1));
        press_b(KEY_CLR, 22);
        double_rise_b(5'd4, 21);
        chk("b_lock21_disp", 64'(disp_b), 64'h44);
        chk("b_lock21_cnt",  64'(cnt_b),  64'(2));

        // Instance B: random stimulus against the list-based model.
        kk_b = 1'b0;
        bus_b.out_ready = 1'b0;
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        m_digs.delete();
        m_ovf  = 1'b0;
        m_send = 1'b0;
        m_data = '0;
        m_prev = 1'b0;
        m_last = -1000;
        m_cyc  = 0;
        for (int n = 0; n < 4000; n++) begin
            logic rise;
            chk("rnd_valid", 64'(bus_b.out_valid), 64'(m_send));
            chk("rnd_data",  64'(bus_b.out_data),  64'(m_data));
            chk("rnd_disp",  64'(disp_b),          64'(m_value()));
            chk("rnd_cnt",   64'(cnt_b),           64'(m_digs.size()));
            chk("rnd_ovf",   64'(ovf_b),           64'(m_ovf));
            if ($urandom_range(0, 4) == 0) kk_b = ~kk_b;
            kc_b = 5'($urandom_range(0, 19));
            bus_b.out_ready = ($urandom_range(0, 3) == 0);
            rise = kk_b & ~m_prev;
            m_prev = kk_b;
            if (m_send) begin
                if (bus_b.out_ready) m_send = 1'b0;
            end else if (rise && (m_cyc - m_last > LB)) begin
                m_last = m_cyc;
                m_key(kc_b);
            end
            m_cyc++;
            cycles(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequences the keypad encoder output into multi-digit hex operands and hands each operand to a downstream consumer over a valid/ready handshake.
- Sits between the keypad encoder (5-bit key code plus key strobe) and the consumer, for example an operand or instruction-load path.
- Provides edge detection, debounce lockout, digit accumulation, edit keys and output buffering.

Parameters:
- WIDTH, 32, operand width in bits; multiple of 4.
- LOCKOUT, 255, cycles after an accepted key during which further strobes are ignored; valid range 0..255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- keycode  in  5  encoded key; 0..15 hex digit, 16 BKSP, 17 CLR, 18 ENTER, 19 reserved
- keyclk  in  1  key-present strobe from encoder; level, high while any key is held
- out_ready  in  1  consumer ready
- out_valid  out  1  operand available
- out_data  out  WIDTH  operand
- disp_data  out  WIDTH  current accumulator, for display
- digit_cnt  out  $clog2(WIDTH/4+1)  digits entered
- overflow  out  1  sticky flag: digits were lost off the top

Behaviour:
- Reset (rst=0 at posedge clk), applied in any state including mid-SEND:
  - state=ENTRY; all outputs 0; accumulator, lockout counter and keyclk history all 0.
- Edge detect: key_evt = keyclk & ~keyclk_q & (lock_cnt==0) & (state==ENTRY).
  - keycode is sampled in the same cycle as key_evt.
  - Effects appear one clock later (latency 1).
  - A key held high produces exactly one event.
- Lockout: any key_evt loads lock_cnt=LOCKOUT; lock_cnt decrements each cycle to 0.
  - A rising edge of keyclk while lock_cnt!=0 is dropped, not deferred.
- Digit key (0..15):
  - acc = {acc[WIDTH-5:0], keycode[3:0]}.
  - If digit_cnt < WIDTH/4: digit_cnt+1.
  - Else: digit_cnt holds and overflow is set to 1 (top nibble lost).
- BKSP (16): acc = acc >> 4; digit_cnt-1, saturating at 0; overflow unchanged.
- CLR (17): acc=0, digit_cnt=0, overflow=0.
- ENTER (18):
  - If digit_cnt==0: ignored, but lockout is still loaded.
  - Else: out_data=acc, out_valid=1, acc=0, digit_cnt=0, overflow=0, state=SEND.
- Key 19: no-op; lockout is still loaded.
- States:
  - ENTRY: accepts key events.
  - SEND: out_valid=1 and out_data is stable; all key events are ignored, and keyclk_q still tracks keyclk.
  - SEND -> ENTRY on the cycle where out_valid & out_ready; out_valid=0 the next cycle.
  - Handshake rules: out_valid is never dropped without out_ready; out_data does not change while out_valid=1.
- Simultaneous out_ready handshake and keyclk rise in SEND: the key is ignored (state is still SEND in that cycle).
- disp_data mirrors acc every cycle.
- Width rules: all shifts are logical; no arithmetic on the operand.

Decomposition:
- keypad_pkg:
  - key code localparams KEY_BKSP=5'd16, KEY_CLR=5'd17, KEY_ENTER=5'd18, KEY_RSVD=5'd19.
  - state enum {ENTRY, SEND}.
- Sub-module key_event_gate:
  - Contains keyclk_q register, lockout counter and enable input.
  - Outputs a single-cycle key_accept pulse.
- The top level holds the accumulator, FSM and output register.

Test Plan:
- Reset, then keys 1,2,3 (each strobe 4 cycles high, gaps > LOCKOUT), then ENTER, out_ready=1:
  - out_valid=1 for one cycle with out_data=0x123; digit_cnt returns to 0.
- ENTER with out_ready=0 for 10 cycles, with key 5 strobed during the wait:
  - out_valid holds at 1 and out_data is stable; the 5 is discarded; after out_ready, disp_data=0.
- WIDTH=8; keys A,B,C:
  - disp_data=0xBC, digit_cnt=2, overflow=1.
- Then CLR:
  - disp_data=0, digit_cnt=0, overflow=0.
- Keys 7,8 then BKSP:
  - disp_data=0x7, digit_cnt=1.
- BKSP x2 from empty:
  - digit_cnt stays 0, disp_data=0.
- LOCKOUT=20; key 4, then a second key-4 strobe rising 10 cycles later:
  - only one digit is accepted (disp_data=0x4).
- ENTER with 0 digits:
  - no out_valid.
- rst=0 for one cycle while in SEND with out_data=0x55:
  - out_valid=0, out_data=0, state ENTRY on the next cycle.
